// File: rtl/i2s_pkg.sv
// Types and constants shared by the I2S transmitter and receiver.
package i2s_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_e;

    localparam int unsigned I2S_DEFAULT_DEPTH = 16;
    localparam int unsigned I2S_BITCNT_W      = 6;

endpackage

// File: rtl/i2s_rx_edge_sync.sv
// Synchronizes {bclk, wclk, din} into the mclk domain through one shared
// pipeline and produces a single-cycle strobe on each synced bclk rise.
module i2s_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic bclk,
    input  logic wclk,
    input  logic din,
    output logic ws,
    output logic d,
    output logic bclk_rise
);

    logic [2:0] raw;
    logic [2:0] synced;
    logic       bclk_prev;

    assign raw = {bclk, wclk, din};

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign synced = raw;
        end else begin : g_sync
            // All three lines share one pipeline so their relative alignment survives.
            logic [2:0] pipe [SYNC_STAGES];

            always_ff @(posedge mclk) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= raw;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign synced = pipe[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            bclk_prev <= 1'b0;
        end else begin
            bclk_prev <= synced[2];
        end
    end

    assign ws        = synced[1];
    assign d         = synced[0];
    assign bclk_rise = synced[2] & ~bclk_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: assembles left/right channel words from the synced serial
// stream and presents each completed stereo pair on a valid/ready register.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_DEPTH = I2S_DEFAULT_DEPTH,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    mclk,
    input  logic                    reset_n,
    input  logic                    bclk,
    input  logic                    wclk,
    input  logic                    din,
    output logic [SAMPLE_DEPTH-1:0] out_l,
    output logic [SAMPLE_DEPTH-1:0] out_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    locked,
    output logic                    overrun,
    output logic                    frame_err
);

    logic                    ws;
    logic                    d;
    logic                    bclk_rise;
    chan_e                   ws_prev;
    logic [I2S_BITCNT_W-1:0] k;
    logic [SAMPLE_DEPTH-1:0] shreg;
    logic [SAMPLE_DEPTH-1:0] word_next;
    logic [SAMPLE_DEPTH-1:0] l_word;
    logic                    ws_change;
    logic                    short_slot;
    logic                    pair_done;
    logic                    load;

    i2s_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .mclk     (mclk),
        .reset_n  (reset_n),
        .bclk     (bclk),
        .wclk     (wclk),
        .din      (din),
        .ws       (ws),
        .d        (d),
        .bclk_rise(bclk_rise)
    );

    // Current word with this rise's bit merged in; bits past SAMPLE_DEPTH never match.
    always_comb begin
        word_next = shreg;
        for (int unsigned i = 0; i < SAMPLE_DEPTH; i++) begin
            if (32'(k) == SAMPLE_DEPTH - 1 - i) begin
                word_next[i] = d;
            end
        end
    end

    assign ws_change  = (chan_e'(ws) != ws_prev);
    assign short_slot = (32'(k) + 32'd1) < SAMPLE_DEPTH;
    assign pair_done  = bclk_rise && ws_change && (ws_prev == RIGHT) && locked;
    assign load       = pair_done && (!out_valid || out_ready);

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            ws_prev   <= RIGHT;
            k         <= '0;
            shreg     <= '0;
            l_word    <= '0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (bclk_rise) begin
                if (ws_change) begin
                    // Clearing the assembly register here zero-fills short slots.
                    ws_prev <= chan_e'(ws);
                    k       <= '0;
                    shreg   <= '0;
                    if (locked && short_slot) begin
                        frame_err <= 1'b1;
                    end
                    if (ws_prev == LEFT) begin
                        l_word <= word_next;
                    end else begin
                        locked <= 1'b1;
                    end
                end else begin
                    shreg <= word_next;
                    if (k != '1) begin
                        k <= k + I2S_BITCNT_W'(1);
                    end
                end
            end

            if (load) begin
                out_l     <= l_word;
                out_r     <= word_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (pair_done && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
